// File: rtl/rf_pkg.sv
// Shared types and constants for the multiport register file and its clear sequencer.
package rf_pkg;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 5;

    // Low bit of port 'port' inside a bus of equal-width packed fields.
    function automatic int rf_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Soft-clear sequencer: sweeps every entry once, one per cycle, then pulses done.
// Requests arriving while a sweep or its done pulse is in flight are ignored.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_IDLE: begin
                if (clr_req_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                // Last entry ends the sweep; the counter holds rather than wrapping to 0.
                if (cnt_q == '1) begin
                    state_d = RF_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            RF_DONE: state_d = RF_IDLE;
            default: state_d = RF_IDLE;
        endcase
    end

    assign clr_busy_o = (state_q == RF_CLEAR);
    assign clr_done_o = (state_q == RF_DONE);
    assign clr_en_o   = (state_q == RF_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_multiport.sv
// Multiport register file: combinational reads with optional same-cycle write bypass,
// one write port stalled (wr_ready low) during soft clear. REG_FILE_ZERO_REG_EN hardwires entry 0 to zero.
module reg_file_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;

    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_req_i  (clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr)
    );

    assign wr_ready = ~clr_busy;
    assign wr_fire  = wr_en & wr_ready;

    // Clear and write are mutually exclusive because wr_ready is low throughout the sweep.
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else if (wr_fire) begin
            mem_d[wr_addr] = wr_data;
        end
        if (ZERO_REG) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = rd_addr[rf_lsb(i, ADDR_W) +: ADDR_W];

        always_comb begin
            rd = mem_q[ra];
            if ((BYPASS != 0) && wr_fire && (ra == wr_addr)) begin
                rd = wr_data;
            end
            if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end
            // Reads are combinational, so force zero while reset is held.
            if (!rst) begin
                rd = '0;
            end
        end

        assign rd_data[rf_lsb(i, DATA_W) +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport: a bypassing 2-port instance and a non-bypassing 4-port
// instance share write/clear inputs and are checked every cycle against a cycle-indexed model.
module tb_reg_file_multiport;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ra [4];
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_req = 1'b0;

    wire [2*AW-1:0] rd_addr_a = {ra[1], ra[0]};
    wire [4*AW-1:0] rd_addr_b = {ra[3], ra[2], ra[1], ra[0]};
    logic [2*DW-1:0] rd_data_a;
    logic [4*DW-1:0] rd_data_b;
    logic wr_ready_a, clr_busy_a, clr_done_a;
    logic wr_ready_b, clr_busy_b, clr_done_b;

    always #5 clk = ~clk;

    reg_file_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_a),
        .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
    );

    reg_file_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_b),
        .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    // Model: array contents plus the cycle index at which the last accepted clear request was sampled.
    logic [DW-1:0] mem_m [DEPTH];
    int cyc   = 0;
    int clr_t = -1000;
    int tests = 0;
    int fails = 0;

    function automatic bit m_busy();
        return (cyc >= clr_t + 1) && (cyc <= clr_t + DEPTH);
    endfunction

    function automatic bit m_done();
        return cyc == clr_t + DEPTH + 1;
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
        if (ZR && a == '0) return '0;
        if (byp && wr_en && !m_busy() && a == wr_addr) return wr_data;
        return mem_m[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":busy_a"}, 32'(clr_busy_a), 32'(m_busy()));
        chk({where, ":busy_b"}, 32'(clr_busy_b), 32'(m_busy()));
        chk({where, ":done_a"}, 32'(clr_done_a), 32'(m_done()));
        chk({where, ":done_b"}, 32'(clr_done_b), 32'(m_done()));
        chk({where, ":ready_a"}, 32'(wr_ready_a), 32'(!m_busy()));
        chk({where, ":ready_b"}, 32'(wr_ready_b), 32'(!m_busy()));
        for (int p = 0; p < 2; p++)
            chk($sformatf("%s:a_rd%0d@%0d", where, p, ra[p]), 32'(rd_data_a[p*DW +: DW]), 32'(m_rd(ra[p], 1'b1)));
        for (int p = 0; p < 4; p++)
            chk($sformatf("%s:b_rd%0d@%0d", where, p, ra[p]), 32'(rd_data_b[p*DW +: DW]), 32'(m_rd(ra[p], 1'b0)));
    endtask

    task automatic check_reset_state(input string where);
        chk({where, ":busy"}, {31'd0, clr_busy_a, clr_busy_b} == 33'd0 ? 32'd0 : 32'd1, 32'd0);
        chk({where, ":done"}, 32'({clr_done_a, clr_done_b}), 32'd0);
        chk({where, ":ready"}, 32'({wr_ready_a, wr_ready_b}), 32'd3);
        chk({where, ":rd_a"}, rd_data_a, 32'd0);
        chk({where, ":rd_b"}, 32'(rd_data_b[63:32] | rd_data_b[31:0]), 32'd0);
    endtask

    task automatic model_edge();
        if (m_busy()) begin
            mem_m[cyc - clr_t - 1] = '0;
        end else begin
            if (wr_en && !(ZR && wr_addr == '0)) mem_m[wr_addr] = wr_data;
            if (clr_req && !m_done()) clr_t = cyc;
        end
        cyc++;
    endtask

    task automatic step(input string where);
        @(negedge clk);
        check_all(where);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
        clr_t = -1000;
    endtask

    task automatic read_all(input string where);
        wr_en = 1'b0; clr_req = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(31 - a); ra[2] = AW'(a ^ 5); ra[3] = AW'(a + 1);
            step(where);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        wr_en = 1'b0; clr_req = 1'b0;
        while ((m_busy() || m_done()) && n < 100) begin
            step("drain");
            n++;
        end
    endtask

    initial begin
        for (int p = 0; p < 4; p++) ra[p] = AW'(p);
        model_reset();

        // Reset state
        #3;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 16'hDEAD;
        #1;
        check_reset_state("reset");
        wr_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Basic writes and reads
        wr_en = 1'b1; wr_addr = 5'd3;  wr_data = 16'hBEEF; step("wr3");
        wr_addr = 5'd31; wr_data = 16'h1234; step("wr31");
        wr_en = 1'b0; ra[0] = 5'd3; ra[1] = 5'd31; step("rd3_31");
        chk("basic_r3", 32'(rd_data_a[15:0]), 32'h0000BEEF);
        read_all("basic_all");

        // Bypass: same-cycle forwarding on dut_a, stored value on dut_b
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'hA5A5;
        for (int p = 0; p < 4; p++) ra[p] = 5'd7;
        step("bypass");
        wr_en = 1'b0; step("bypass_next");

        // Zero register / all ports on entry 0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFFFF;
        for (int p = 0; p < 4; p++) ra[p] = 5'd0;
        step("zr_same");
        wr_en = 1'b0; step("zr_next");

        // Soft clear of a full array with a write held during busy
        wr_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            wr_addr = AW'(a); wr_data = DW'(a + 1); step("fill");
        end
        wr_en = 1'b0; clr_req = 1'b1; ra[0] = 5'd9; ra[1] = 5'd20; step("clr_req");
        clr_req = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h9999;
        for (int k = 0; k < DEPTH; k++) step("clr_busy");
        wr_en = 1'b0; step("clr_done");
        step("clr_after");
        read_all("clr_all");

        // Simultaneous clear request and write, plus a second request mid-sweep
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h00FF; clr_req = 1'b1; ra[0] = 5'd5; step("sim_req");
        wr_en = 1'b0; clr_req = 1'b0;
        for (int k = 0; k < 16; k++) step("sim_sweep");
        clr_req = 1'b1; step("sim_req2");
        clr_req = 1'b0;
        for (int k = 0; k < 20; k++) step("sim_tail");

        // Reset in the tenth cycle of a sweep
        wr_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            wr_addr = AW'(a); wr_data = DW'(16'h100 + a); step("refill");
        end
        wr_en = 1'b0; clr_req = 1'b1; step("rst_clr_req");
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) step("rst_sweep");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_state("mid_clear_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        read_all("post_rst");

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = DW'($urandom);
            clr_req = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < 4; p++)
                ra[p] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            step("rand");
        end
        wait_idle();
        read_all("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
